sdram_init_sequencer: RTL
=========================

# sdram_init_sequencer

Power-up initialization sequencer between the SDRAM clock PLL and the SDRAM controller command path. It consumes the PLL `locked` output and runs in the 143 MHz `outclk_0` domain. After lock it waits the JEDEC power-up interval, then issues PRECHARGE-ALL, the auto-refresh burst and LOAD MODE REGISTER. It then hands the command bus to the controller by asserting `init_done`.

## Interface
- `POWERUP_CYCLES`, 14300: NOP cycles after lock before the first command (100 µs at 143 MHz).
- `TRP_CYCLES`, 3: idle cycles after PRECHARGE.
- `TRFC_CYCLES`, 10: idle cycles after each AUTO REFRESH.
- `TMRD_CYCLES`, 2: idle cycles after LOAD MODE.
- `REFRESH_COUNT`, 8: number of AUTO REFRESH commands.
- `MODE_REG`, 13'h0030: mode register value (CAS 3, burst 1, sequential).
- `clk` in 1: PLL `outclk_0`.
- `rst` in 1: asynchronous, active-high reset.
- `pll_locked` in 1: PLL lock, asynchronous to `clk`.
- `cke` out 1: SDRAM clock enable.
- `cmd` out 4: {cs_n, ras_n, cas_n, we_n}.
- `addr` out 13: SDRAM address.
- `ba` out 2: bank address.
- `init_done` out 1: initialization complete; controller owns the bus.

## Operation
- `pll_locked` passes through a 2-flop synchronizer (`lock_s`); all decisions use `lock_s`.
- Command encodings:
  - NOP = 4'b0111
  - PRECHARGE = 4'b0010
  - AUTO REFRESH = 4'b0001
  - LOAD MODE = 4'b0000
- States and transitions:
  - WAIT_LOCK → POWERUP when `lock_s`=1.
  - POWERUP: counter loads POWERUP_CYCLES−1 and decrements; → PRECHARGE at 0.
  - PRECHARGE: one cycle, `addr[10]`=1 (all banks); → WAIT_TRP.
  - WAIT_TRP: TRP_CYCLES cycles → REFRESH.
  - REFRESH: one cycle, refresh counter +1; → WAIT_TRFC.
  - WAIT_TRFC: TRFC_CYCLES cycles → REFRESH while refresh count < REFRESH_COUNT, otherwise → LOAD_MODE.
  - LOAD_MODE: one cycle, `addr`=MODE_REG, `ba`=0; → WAIT_TMRD.
  - WAIT_TMRD: TMRD_CYCLES cycles → DONE.
  - DONE: `init_done`=1, holds.
- `cke`:
  - 0 in WAIT_LOCK.
  - 1 from the POWERUP entry onward.
- Outside the single command cycles: `cmd`=NOP, `addr`=0, `ba`=0.
- Loss of `lock_s` in any state other than WAIT_LOCK and DONE → WAIT_LOCK next cycle. Counters clear, `cke`=0, `cmd`=NOP. A partial sequence restarts from the beginning on re-lock.
- Counter width: `$clog2(POWERUP_CYCLES+1)` bits, shared by all wait states. Refresh counter width: `$clog2(REFRESH_COUNT+1)` bits.
- `rst` asserted at any time → all outputs and state return to reset values immediately; this is asynchronous.

## Timing
- Reset values: `cke`=0, `cmd`=4'b0111, `addr`=0, `ba`=0, `init_done`=0, state WAIT_LOCK.
- All outputs are registered. A transition decided at edge n appears on the outputs after edge n.
- Edge-count definitions:
  - `pll_locked` rising → `lock_s`=1 after 2 edges.
  - PRECHARGE appears POWERUP_CYCLES+1 cycles after the first `lock_s`=1 cycle.
  - Spacing between consecutive refresh commands: TRFC_CYCLES+1 cycles.
- Total latency from `lock_s` to `init_done` = POWERUP_CYCLES + 1 + TRP_CYCLES + REFRESH_COUNT·(1+TRFC_CYCLES) + 1 + TMRD_CYCLES + 1.
- Exactly one non-NOP command per command state; never two consecutive non-NOP cycles.

## Configuration
- `SDRAM_INIT_LOCK_WATCH_EN` defined: loss of `lock_s` in DONE also → WAIT_LOCK. `init_done` and `cke` drop the next cycle and full re-initialization follows re-lock.
- Not defined: DONE is terminal until `rst`; `lock_s` is ignored after DONE.

## Structure
- Shared package `sdram_pkg` holds:
  - the command encoding constants (CMD_NOP, CMD_PRECHARGE, CMD_REFRESH, CMD_LOAD_MODE);
  - the state enum `init_state_t`;
  - the widths SDRAM_ADDR_W=13 and SDRAM_BA_W=2.
- One sub-module: `sync_2ff`, a generic 2-flop synchronizer with async active-high reset, used for `pll_locked`.

## Test plan
- Reset release, `pll_locked`=0 for 1000 cycles → `cke`=0, `cmd`=NOP, `init_done`=0 throughout.
- `pll_locked` rises at cycle 10 (POWERUP_CYCLES overridden to 20) → PRECHARGE with `addr`=0x400 on cycle 10+2+21, followed by 3 NOP cycles.
- Full sequence → exactly 8 AUTO REFRESH commands spaced 11 cycles apart; then LOAD MODE with `addr`=0x0030 and `ba`=0; `init_done`=1 three cycles later.
- `pll_locked` drops after the 4th refresh → WAIT_LOCK, `cke`=0. Re-lock → a fresh sequence that issues all 8 refreshes again.
- `rst` pulsed during WAIT_TRFC → outputs at reset values on the same cycle, with no clock edge needed; sequence restarts after release.
- `pll_locked` drops in DONE: with `SDRAM_INIT_LOCK_WATCH_EN`, `init_done`→0 and `cke`→0 within 3 cycles; without it, `init_done` stays 1.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, init sequencer states and bus widths.
package sdram_pkg;

  localparam int SDRAM_ADDR_W = 13;
  localparam int SDRAM_BA_W   = 2;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_REFRESH   = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

  typedef enum logic [3:0] {
    ST_WAIT_LOCK,
    ST_POWERUP,
    ST_PRECHARGE,
    ST_WAIT_TRP,
    ST_REFRESH,
    ST_WAIT_TRFC,
    ST_LOAD_MODE,
    ST_WAIT_TMRD,
    ST_DONE
  } init_state_t;

endpackage

// File: rtl/sdram_init_sequencer_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/sdram_init_sequencer.sv
// SDRAM power-up sequencer: waits for PLL lock, then PRECHARGE-ALL, refresh burst, LOAD MODE.
// Define SDRAM_INIT_LOCK_WATCH_EN to also restart from DONE when PLL lock is lost.
module sdram_init_sequencer
  import sdram_pkg::*;
#(
  parameter int                      POWERUP_CYCLES = 14300,
  parameter int                      TRP_CYCLES     = 3,
  parameter int                      TRFC_CYCLES    = 10,
  parameter int                      TMRD_CYCLES    = 2,
  parameter int                      REFRESH_COUNT  = 8,
  parameter logic [SDRAM_ADDR_W-1:0] MODE_REG       = 13'h0030
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pll_locked,
  output logic                    cke,
  output logic [3:0]              cmd,
  output logic [SDRAM_ADDR_W-1:0] addr,
  output logic [SDRAM_BA_W-1:0]   ba,
  output logic                    init_done
);

  localparam int CNT_W = $clog2(POWERUP_CYCLES + 1);
  localparam int REF_W = $clog2(REFRESH_COUNT + 1);

  logic                    w_lock_s;
  logic                    w_abort;
  init_state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic [REF_W-1:0]        r_ref, w_ref_nxt;
  logic                    r_cke, w_cke_nxt;
  logic [3:0]              r_cmd, w_cmd_nxt;
  logic [SDRAM_ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [SDRAM_BA_W-1:0]   r_ba, w_ba_nxt;
  logic                    r_done, w_done_nxt;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .i_d (pll_locked),
    .o_q (w_lock_s)
  );

`ifdef SDRAM_INIT_LOCK_WATCH_EN
  assign w_abort = !w_lock_s && (r_state != ST_WAIT_LOCK);
`else
  assign w_abort = !w_lock_s && (r_state != ST_WAIT_LOCK) && (r_state != ST_DONE);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_WAIT_LOCK;
      r_cnt   <= '0;
      r_ref   <= '0;
      r_cke   <= 1'b0;
      r_cmd   <= CMD_NOP;
      r_addr  <= '0;
      r_ba    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ref   <= w_ref_nxt;
      r_cke   <= w_cke_nxt;
      r_cmd   <= w_cmd_nxt;
      r_addr  <= w_addr_nxt;
      r_ba    <= w_ba_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Each wait state preloads its interval minus one so it lasts exactly that many cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ref_nxt   = r_ref;
    case (r_state)
      ST_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = ST_POWERUP;
          w_cnt_nxt   = CNT_W'(POWERUP_CYCLES - 1);
          w_ref_nxt   = '0;
        end
      end
      ST_POWERUP: begin
        if (r_cnt == '0) w_state_nxt = ST_PRECHARGE;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      ST_PRECHARGE: begin
        w_state_nxt = ST_WAIT_TRP;
        w_cnt_nxt   = CNT_W'(TRP_CYCLES - 1);
      end
      ST_WAIT_TRP: begin
        if (r_cnt == '0) w_state_nxt = ST_REFRESH;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      ST_REFRESH: begin
        w_state_nxt = ST_WAIT_TRFC;
        w_cnt_nxt   = CNT_W'(TRFC_CYCLES - 1);
        w_ref_nxt   = r_ref + REF_W'(1);
      end
      ST_WAIT_TRFC: begin
        if (r_cnt != '0)                        w_cnt_nxt   = r_cnt - CNT_W'(1);
        else if (r_ref < REF_W'(REFRESH_COUNT)) w_state_nxt = ST_REFRESH;
        else                                    w_state_nxt = ST_LOAD_MODE;
      end
      ST_LOAD_MODE: begin
        w_state_nxt = ST_WAIT_TMRD;
        w_cnt_nxt   = CNT_W'(TMRD_CYCLES - 1);
      end
      ST_WAIT_TMRD: begin
        if (r_cnt == '0) w_state_nxt = ST_DONE;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      ST_DONE: ;
      default: w_state_nxt = ST_WAIT_LOCK;
    endcase
    if (w_abort) begin
      w_state_nxt = ST_WAIT_LOCK;
      w_cnt_nxt   = '0;
      w_ref_nxt   = '0;
    end
  end

  // Outputs decode the next state so they change on the same edge as the state register.
  always_comb begin
    w_cke_nxt  = (w_state_nxt != ST_WAIT_LOCK);
    w_done_nxt = (w_state_nxt == ST_DONE);
    w_cmd_nxt  = CMD_NOP;
    w_addr_nxt = '0;
    w_ba_nxt   = '0;
    case (w_state_nxt)
      ST_PRECHARGE: begin
        w_cmd_nxt      = CMD_PRECHARGE;
        w_addr_nxt[10] = 1'b1;
      end
      ST_REFRESH:   w_cmd_nxt = CMD_REFRESH;
      ST_LOAD_MODE: begin
        w_cmd_nxt  = CMD_LOAD_MODE;
        w_addr_nxt = MODE_REG;
      end
      default: ;
    endcase
  end

  assign cke       = r_cke;
  assign cmd       = r_cmd;
  assign addr      = r_addr;
  assign ba        = r_ba;
  assign init_done = r_done;

endmodule
